// File: rtl/uart_pkg.sv
// Shared constants and controller state encoding for the UART transmit path.
package uart_pkg;

    localparam int unsigned SYS_CLK        = 50_000_000;
    localparam int unsigned BAUD_RATE      = 115_200;
    localparam int unsigned BITS_PER_FRAME = 10;
    localparam int unsigned CLKS_PER_FRAME = (SYS_CLK / BAUD_RATE) * BITS_PER_FRAME;

    // Default watchdog: smallest power of two that covers one full frame.
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1 << $clog2(CLKS_PER_FRAME + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// Host write port and transmitter handshake of the UART TX buffer controller.
interface uart_tx_fifo_ctrl_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_d;
    logic              o_full;
    logic              o_empty;
    logic [CNT_W-1:0]  o_count;
    logic [DATA_W-1:0] o_tx_d;
    logic              o_tx_en;
    logic              i_tx_complete;
    logic              o_busy;
    logic              o_overflow;
    logic              o_timeout;
    logic              i_clr_err;

    modport slave (
        input  i_wr_en, i_wr_d, i_tx_complete, i_clr_err,
        output o_full, o_empty, o_count, o_tx_d, o_tx_en, o_busy, o_overflow, o_timeout
    );

    modport master (
        output i_wr_en, i_wr_d, i_tx_complete, i_clr_err,
        input  o_full, o_empty, o_count, o_tx_d, o_tx_en, o_busy, o_overflow, o_timeout
    );

endinterface

// File: rtl/uart_tx_fifo_ctrl_sync_fifo.sv
// Single-clock FIFO; full/empty decode the registered occupancy count.
module sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [DATA_W-1:0]            i_wr_d,
    input  logic                         i_rd_en,
    output logic [DATA_W-1:0]            o_rd_d,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rd_d  = r_mem[r_rd_ptr];
    assign w_push  = i_wr_en && !o_full;
    assign w_pop   = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte buffer and start/complete sequencer feeding Top_UART_Tx, with
// inter-frame gap, completion watchdog and sticky error flags.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_fifo_ctrl_if.slave  bus
);
    localparam int unsigned WD_W       = min1_clog2(TIMEOUT_CYCLES);
    localparam int unsigned GAP_W      = min1_clog2(GAP_CYCLES + 1);
    localparam int unsigned GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

    tx_state_t                  r_state;
    logic [WD_W-1:0]            r_wd;
    logic [GAP_W-1:0]           r_gap;
    logic [DATA_W-1:0]          r_tx_d;
    logic                       r_tx_en;
    logic                       r_busy;
    logic                       r_overflow;
    logic                       r_timeout;
    logic [DATA_W-1:0]          w_fifo_d;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(DEPTH+1)-1:0] w_count;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_to_evt;

    assign w_pop    = (r_state == ST_IDLE) && !w_empty;
    assign w_drop   = bus.i_wr_en && w_full;
    assign w_to_evt = (r_state == ST_WAIT) && !bus.i_tx_complete && (r_wd == WD_LAST);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (bus.i_wr_en),
        .i_wr_d  (bus.i_wr_d),
        .i_rd_en (w_pop),
        .o_rd_d  (w_fifo_d),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tx_d  <= '0;
            r_tx_en <= 1'b0;
            r_busy  <= 1'b0;
            r_wd    <= '0;
            r_gap   <= '0;
        end else begin
            r_tx_en <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_d  <= w_fifo_d;
                        r_tx_en <= 1'b1;
                        r_wd    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Completion takes priority over a watchdog expiring on the same edge.
                    if (bus.i_tx_complete) begin
                        r_gap <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A new error event on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_drop)             r_overflow <= 1'b1;
            else if (bus.i_clr_err) r_overflow <= 1'b0;
            if (w_to_evt)           r_timeout  <= 1'b1;
            else if (bus.i_clr_err) r_timeout  <= 1'b0;
        end
    end

    assign bus.o_full     = w_full;
    assign bus.o_empty    = w_empty;
    assign bus.o_count    = w_count;
    assign bus.o_tx_d     = r_tx_d;
    assign bus.o_tx_en    = r_tx_en;
    assign bus.o_busy     = r_busy;
    assign bus.o_overflow = r_overflow;
    assign bus.o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl with a behavioural Top_UART_Tx loopback.
module tb_uart_tx_fifo_ctrl;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_fifo_ctrl_if #(.DEPTH(DEPTH), .DATA_W(8)) bus0 ();
    uart_tx_fifo_ctrl_if #(.DEPTH(DEPTH), .DATA_W(8)) bus1 ();

    uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(8), .GAP_CYCLES(5)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         acc;
    int         pops;
    logic       ovf_exp;
    logic       lb_cpl;
    logic       stim_cpl;
    bit         lb_hang;
    bit         lb_manual;
    logic       lb_busy;
    logic [7:0] lb_byte;
    logic [7:0] rx_last;
    int         lb_cnt;
    int         lb_min = 2;
    int         lb_max = 8;

    assign bus0.i_tx_complete = lb_cpl | stim_cpl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: a write is accepted iff occupancy (accepted - transmitted) is below DEPTH.
    task automatic wr0(input logic [7:0] b);
        bus0.i_wr_en = 1'b1;
        bus0.i_wr_d  = b;
        if (acc - pops < DEPTH) begin
            exp_q.push_back(b);
            acc++;
        end else begin
            ovf_exp = 1'b1;
        end
        tick();
        bus0.i_wr_en = 1'b0;
    endtask

    task automatic clr_err();
        bus0.i_clr_err = 1'b1;
        ovf_exp = 1'b0;
        tick();
        bus0.i_clr_err = 1'b0;
    endtask

    task automatic chk_counts(input string nm);
        int m;
        m = acc - pops;
        chk({nm, "_count"}, bus0.o_count, m);
        chk({nm, "_empty"}, bus0.o_empty, m == 0);
        chk({nm, "_full"}, bus0.o_full, m == DEPTH);
        chk({nm, "_ovf"}, bus0.o_overflow, ovf_exp);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_tx_d"}, bus0.o_tx_d, 8'h00);
        chk({nm, "_tx_en"}, bus0.o_tx_en, 1'b0);
        chk({nm, "_count"}, bus0.o_count, 0);
        chk({nm, "_empty"}, bus0.o_empty, 1'b1);
        chk({nm, "_full"}, bus0.o_full, 1'b0);
        chk({nm, "_busy"}, bus0.o_busy, 1'b0);
        chk({nm, "_ovf"}, bus0.o_overflow, 1'b0);
        chk({nm, "_to"}, bus0.o_timeout, 1'b0);
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || bus0.o_busy) && i < 3000) begin
            tick();
            i++;
        end
        chk(nm, exp_q.size() == 0 && !bus0.o_busy, 1'b1);
    endtask

    // Monitor + transmitter loopback: pops the scoreboard on every start pulse.
    initial begin : lb_mon
        lb_cpl  = 1'b0;
        lb_busy = 1'b0;
        lb_byte = '0;
        rx_last = '0;
        lb_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            lb_cpl = 1'b0;
            if (!rst_n) begin
                lb_busy = 1'b0;
            end else begin
                if (lb_busy && stim_cpl) begin
                    lb_busy = 1'b0;
                    rx_last = lb_byte;
                end
                if (bus0.o_tx_en) begin
                    pops++;
                    chk("tx_en_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) chk("tx_byte", bus0.o_tx_d, exp_q.pop_front());
                    if (!lb_hang) begin
                        chk("frame_overlap", lb_busy, 1'b0);
                        lb_busy = 1'b1;
                        lb_byte = bus0.o_tx_d;
                        lb_cnt  = int'($urandom_range(lb_max, lb_min));
                    end
                end else if (lb_busy) begin
                    chk("tx_d_hold", bus0.o_tx_d, lb_byte);
                    if (!lb_manual) begin
                        if (lb_cnt <= 1) begin
                            lb_cpl  = 1'b1;
                            lb_busy = 1'b0;
                            rx_last = lb_byte;
                        end else begin
                            lb_cnt--;
                        end
                    end
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        rst_n     = 1'b1;
        stim_cpl  = 1'b0;
        lb_hang   = 1'b0;
        lb_manual = 1'b0;
        acc       = 0;
        pops      = 0;
        ovf_exp   = 1'b0;
        bus0.i_wr_en = 1'b0; bus0.i_wr_d = '0; bus0.i_clr_err = 1'b0;
        bus1.i_wr_en = 1'b0; bus1.i_wr_d = '0; bus1.i_clr_err = 1'b0; bus1.i_tx_complete = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single byte: start pulse on the second edge after the write.
        wr0(8'h55);
        chk("lat_edge_n", bus0.o_tx_en, 1'b0);
        tick();
        chk("lat_tx_en", bus0.o_tx_en, 1'b1);
        chk("lat_tx_d", bus0.o_tx_d, 8'h55);
        chk("lat_busy", bus0.o_busy, 1'b1);
        drain("drain_single");
        chk("rx_byte", rx_last, 8'h55);
        chk("single_pulse", pops, 1);
        chk("idle_busy", bus0.o_busy, 1'b0);

        // Burst to full, overflow, drop on the pop edge.
        lb_manual = 1'b1;
        for (int i = 1; i <= 16; i++) wr0(8'(i));
        chk_counts("burst16");
        wr0(8'hAA);
        chk_counts("burst17");
        chk("full_after_17", bus0.o_full, 1'b1);
        wr0(8'hBB);
        chk("ovf_set", bus0.o_overflow, 1'b1);
        chk_counts("burst18");
        clr_err();
        chk("ovf_clr", bus0.o_overflow, 1'b0);
        stim_cpl = 1'b1; tick(); stim_cpl = 1'b0;
        wr0(8'hCC);
        chk("b2b_tx_en", bus0.o_tx_en, 1'b1);
        chk("ovf_pop_same", bus0.o_overflow, 1'b1);
        chk_counts("burst_pop");
        lb_manual = 1'b0;
        drain("drain_burst");
        clr_err();

        // Simultaneous write and pop at occupancy 3.
        lb_manual = 1'b1;
        for (int i = 0; i < 4; i++) wr0(8'h21 + 8'(i));
        chk_counts("pre_simul");
        stim_cpl = 1'b1; tick(); stim_cpl = 1'b0;
        chk("simul_idle", bus0.o_tx_en, 1'b0);
        wr0(8'h25);
        chk("simul_count", bus0.o_count, 3);
        chk("simul_tx_en", bus0.o_tx_en, 1'b1);
        lb_manual = 1'b0;
        drain("drain_simul");

        // Pointer wrap across two batches.
        for (int i = 0; i < 12; i++) wr0(8'($urandom));
        drain("drain_wrap1");
        for (int i = 0; i < 8; i++) wr0(8'($urandom));
        drain("drain_wrap2");

        // Random traffic with slow frames.
        lb_max = 20;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99, 0) < 45) wr0(8'($urandom));
            else tick();
            chk_counts("rand");
        end
        drain("drain_rand");
        clr_err();
        lb_max = 8;

        // Watchdog with a hung transmitter.
        lb_hang = 1'b1;
        wr0(8'h71);
        wr0(8'h72);
        chk("to_start", bus0.o_tx_en, 1'b1);
        repeat (63) tick();
        chk("to_before", bus0.o_timeout, 1'b0);
        chk("to_busy", bus0.o_busy, 1'b1);
        tick();
        chk("to_set", bus0.o_timeout, 1'b1);
        chk("to_idle", bus0.o_busy, 1'b0);
        tick();
        chk("to_next_start", bus0.o_tx_en, 1'b1);
        repeat (62) tick();
        bus0.i_clr_err = 1'b1; tick(); bus0.i_clr_err = 1'b0;
        chk("to_clr", bus0.o_timeout, 1'b0);
        bus0.i_clr_err = 1'b1; tick(); bus0.i_clr_err = 1'b0;
        chk("to_set_wins", bus0.o_timeout, 1'b1);
        clr_err();
        chk("to_clr2", bus0.o_timeout, 1'b0);
        lb_hang = 1'b0;

        // Inter-frame gap of 5 on the second instance.
        bus1.i_wr_en = 1'b1; bus1.i_wr_d = 8'h81; tick();
        bus1.i_wr_d = 8'h82; tick();
        bus1.i_wr_en = 1'b0;
        chk("gap_first_en", bus1.o_tx_en, 1'b1);
        chk("gap_first_d", bus1.o_tx_d, 8'h81);
        bus1.i_tx_complete = 1'b1; tick(); bus1.i_tx_complete = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("gap_clk%0d", k), bus1.o_tx_en, k == 6);
            if (k == 3) chk("gap_busy", bus1.o_busy, 1'b1);
        end
        chk("gap_second_d", bus1.o_tx_d, 8'h82);

        // Asynchronous reset in WAIT with 4 bytes queued, then a late completion.
        lb_manual = 1'b1;
        for (int i = 0; i < 5; i++) wr0(8'h91 + 8'(i));
        chk_counts("pre_rst");
        #3 rst_n = 1'b0;
        #1;
        chk_reset("arst");
        exp_q.delete();
        acc = 0;
        pops = 0;
        ovf_exp = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        lb_manual = 1'b0;
        stim_cpl = 1'b1; tick(); stim_cpl = 1'b0;
        repeat (10) tick();
        chk("late_cpl_no_tx", pops, 0);
        chk("late_cpl_busy", bus0.o_busy, 1'b0);
        chk_counts("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
